dmux_1to2_stream_dispatch: RTL and testbench
============================================

Name: dmux_1to2_stream_dispatch

Overview:
- Registered, handshaked front-end for the 1:2 demultiplexer stage. It accepts a word stream on a valid/ready input and steers each word to one of two output channels.
- The channel is chosen either by an internal round-robin pointer or by an explicit select input.
- Each output channel holds one word in a buffer, so a stalled consumer back-pressures the source instead of losing data.
- Per-channel delivery counters support debug and verification.

Parameters:
- WIDTH, 8, data word width in bits.
- CNT_W, 16, width of each per-channel delivery counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active high.
- mode  input  1  0 = round-robin steering, 1 = explicit steering via in_sel.
- in_sel  input  1  target channel when mode=1; ignored when mode=0.
- in_data  input  WIDTH  input word.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a word this cycle.
- out0_data  output  WIDTH  channel 0 word.
- out0_valid  output  1  channel 0 holds a word.
- out0_ready  input  1  channel 0 consumer accepts.
- out1_data  output  WIDTH  channel 1 word.
- out1_valid  output  1  channel 1 holds a word.
- out1_ready  input  1  channel 1 consumer accepts.
- rr_ptr  output  1  current round-robin pointer (state PTR0=0, PTR1=1).
- cnt0  output  CNT_W  words delivered on channel 0.
- cnt1  output  CNT_W  words delivered on channel 1.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. While rst=1 at a clock edge:
  - out0_valid, out1_valid, out0_data, out1_data, rr_ptr, cnt0 and cnt1 all become 0.
  - in_ready is forced to 0 combinationally while rst=1.
- Target channel tgt is combinational: tgt = in_sel when mode=1, else tgt = rr_ptr.
- Channel k is "free" when outk_valid=0, or when outk_valid=1 and outk_ready=1 (it drains this cycle).
- in_ready = !rst and (channel tgt is free). in_ready depends on in_valid never.
- Accept: when in_valid && in_ready at an edge:
  - outtgt_data <= in_data and outtgt_valid <= 1.
  - Latency from input to output is 1 cycle.
- Output handshake on channel k: when outk_valid && outk_ready at an edge:
  - cntk increments by 1, wrapping modulo 2^CNT_W with no saturation.
  - outk_valid clears unless the same edge also accepts a new word into channel k.
- Simultaneous drain and fill on the same channel: the new word is loaded and outk_valid stays 1. Full throughput is 1 word per cycle into a single channel whose consumer keeps ready=1.
- Output stability: while outk_valid=1 and outk_ready=0, outk_data holds its value.
- Round-robin FSM with states PTR0 and PTR1:
  - Transitions only on an accepted word while mode=0: PTR0->PTR1 and PTR1->PTR0.
  - Otherwise the state holds, including while mode=1.
- Strict ordering in round-robin: if the pointed channel is not free, the input stalls even when the other channel is empty. Words are never skipped or reordered.
- Mode change: takes effect combinationally in the same cycle. rr_ptr is retained across mode=1 periods. Switching mode never modifies buffer contents.
- Reset mid-operation: buffered words are discarded, not delivered. Counters return to 0.
- in_sel and mode are sampled only in cycles where in_valid=1. Their values while in_valid=0 have no effect.
- Channels drain independently. A stall on one channel never blocks delivery from the other channel's buffer.

Decomposition:
- Shared package dmux_pkg holds:
  - constants CH0=1'b0 and CH1=1'b1;
  - MODE_RR=1'b0 and MODE_SEL=1'b1;
  - the rr state typedef {PTR0, PTR1}.
- One sub-module is natural: dmux_out_slot (a single-entry data/valid register with its delivery counter). It is instantiated twice, once per channel.
- Steering logic and the round-robin FSM stay in the top module.

Test Plan:
1. Reset, mode=0, WIDTH=8, both readys=1; stream 0x11,0x22,0x33,0x44 back-to-back -> 0x11 and 0x33 appear on out0, 0x22 and 0x44 on out1, each 1 cycle after acceptance; in_ready stays 1 throughout; cnt0=2, cnt1=2.
2. mode=0, out0_ready=0, send 0xA1 then 0xA2 then 0xA3 -> 0xA1 is held on out0 and 0xA2 delivered on out1. in_ready drops to 0 with 0xA3 pending (rr_ptr=PTR0). Raise out0_ready -> 0xA1 drains and 0xA3 loads into out0 on the same edge, with out0_valid remaining 1.
3. mode=1, in_sel=1, 6 consecutive words with out1_ready=1 -> all words go to out1 at 1 word/cycle. out0_valid stays 0, cnt1=6, rr_ptr unchanged.
4. mode=1, out1_ready=0, channel 1 full, in_sel=1 -> in_ready=0. Flip in_sel=0 with out0 empty -> in_ready=1 the same cycle and the word goes to out0.
5. CNT_W=4; deliver 17 words on channel 0 -> cnt0 wraps to 1.
6. Hold words in both buffers, then assert rst for 1 cycle -> both valids=0, rr_ptr=0 and counters=0 on the next cycle. The held words are never delivered, and in_ready=0 during rst.

Source files
------------

// File: rtl/dmux_1to2_stream_dispatch_pkg.sv
// rtl/dmux_1to2_stream_dispatch_pkg.sv - shared constants and round-robin state type for the 1:2 dispatcher
package dmux_pkg;
  localparam logic CH0      = 1'b0;
  localparam logic CH1      = 1'b1;
  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_SEL = 1'b1;

  typedef enum logic {PTR0 = 1'b0, PTR1 = 1'b1} rr_state_t;
endpackage

// File: rtl/dmux_1to2_stream_dispatch_if.sv
// rtl/dmux_1to2_stream_dispatch_if.sv - input stream, two output streams and status bundled as one interface
interface dmux_1to2_stream_dispatch_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             mode;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic             rr_ptr;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // master: the environment driving the source and the two consumers
  modport master (
    output mode, in_sel, in_data, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, rr_ptr, cnt0, cnt1
  );

  modport slave (
    input  mode, in_sel, in_data, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, rr_ptr, cnt0, cnt1
  );
endinterface

// File: rtl/dmux_1to2_stream_dispatch_out_slot.sv
// rtl/dmux_1to2_stream_dispatch_out_slot.sv - single-entry output buffer with wrapping delivery counter
module dmux_out_slot #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             free
);
  logic drain;

  assign drain = valid && ready;
  // a draining slot can take a new word on the same edge, giving full throughput
  assign free  = !valid || ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      if (drain) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (load) begin
        data  <= load_data;
        valid <= 1'b1;
      end else if (drain) begin
        valid <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/dmux_1to2_stream_dispatch.sv
// rtl/dmux_1to2_stream_dispatch.sv - steers a valid/ready word stream to one of two buffered channels
module dmux_1to2_stream_dispatch
  import dmux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  dmux_1to2_stream_dispatch_if.slave       bus
);
  rr_state_t state;
  logic      tgt;
  logic      free0;
  logic      free1;
  logic      accept;
  logic      load0;
  logic      load1;

  assign tgt          = (bus.mode == MODE_SEL) ? bus.in_sel : (state == PTR1);
  // the pointed channel must be free; the other channel is never borrowed, keeping order strict
  assign bus.in_ready = !rst && ((tgt == CH0) ? free0 : free1);
  assign accept       = bus.in_valid && bus.in_ready;
  assign load0        = accept && (tgt == CH0);
  assign load1        = accept && (tgt == CH1);
  assign bus.rr_ptr   = (state == PTR1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= PTR0;
    end else if (accept && (bus.mode == MODE_RR)) begin
      case (state)
        PTR0:    state <= PTR1;
        default: state <= PTR0;
      endcase
    end
  end

  dmux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot0 (
    .clk       (clk),
    .rst       (rst),
    .load      (load0),
    .load_data (bus.in_data),
    .ready     (bus.out0_ready),
    .data      (bus.out0_data),
    .valid     (bus.out0_valid),
    .cnt       (bus.cnt0),
    .free      (free0)
  );

  dmux_out_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot1 (
    .clk       (clk),
    .rst       (rst),
    .load      (load1),
    .load_data (bus.in_data),
    .ready     (bus.out1_ready),
    .data      (bus.out1_data),
    .valid     (bus.out1_valid),
    .cnt       (bus.cnt1),
    .free      (free1)
  );
endmodule

// File: tb/tb_dmux_1to2_stream_dispatch.sv
// tb/tb_dmux_1to2_stream_dispatch.sv - self-checking bench with a queue-based reference model
module tb_dmux_1to2_stream_dispatch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  dmux_1to2_stream_dispatch_if #(.WIDTH(8), .CNT_W(16)) bus ();
  dmux_1to2_stream_dispatch_if #(.WIDTH(8), .CNT_W(4))  bus2 ();

  dmux_1to2_stream_dispatch #(.WIDTH(8), .CNT_W(16)) dut  (.clk(clk), .rst(rst), .bus(bus));
  dmux_1to2_stream_dispatch #(.WIDTH(8), .CNT_W(4))  dut2 (.clk(clk), .rst(rst), .bus(bus2));

  // reference model: buffer contents, delivery counts, pointer and per-channel order queues
  bit         mv[2];
  logic [7:0] md[2];
  int         mc[2];
  bit         mp;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  function automatic bit m_tgt();
    return bus.mode ? bus.in_sel : mp;
  endfunction

  function automatic bit m_ready();
    bit t;
    bit r;
    t = m_tgt();
    r = t ? bus.out1_ready : bus.out0_ready;
    return !rst && (!mv[t] || r);
  endfunction

  task automatic model_edge();
    bit acc;
    bit t;
    bit rdy[2];
    if (rst) begin
      mv = '{0, 0}; md = '{8'h00, 8'h00}; mc = '{0, 0}; mp = 0;
      q0.delete(); q1.delete();
      return;
    end
    acc = bus.in_valid && m_ready();
    t = m_tgt();
    rdy[0] = bus.out0_ready; rdy[1] = bus.out1_ready;
    for (int k = 0; k < 2; k++) begin
      if (mv[k] && rdy[k]) begin
        mc[k] = (mc[k] + 1) % 65536;
        mv[k] = 0;
        if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      end
    end
    if (acc) begin
      mv[t] = 1; md[t] = bus.in_data;
      if (t == 0) q0.push_back(bus.in_data); else q1.push_back(bus.in_data);
      if (!bus.mode) mp = ~mp;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic drive(bit m, bit s, logic [7:0] d, bit v, bit r0, bit r1);
    bus.mode = m; bus.in_sel = s; bus.in_data = d; bus.in_valid = v;
    bus.out0_ready = r0; bus.out1_ready = r1;
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(0, 0, 8'h5A, 1, 1, 1);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    tick();
    tick();
    total++; if ({bus.out0_valid, bus.out1_valid, bus.rr_ptr} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {bus.out0_valid, bus.out1_valid, bus.rr_ptr}); end
    total++; if ({bus.cnt0, bus.cnt1, bus.out0_data, bus.out1_data} !== 48'h0) begin bad++; $display("FAIL reset_regs got=%h exp=0", {bus.cnt0, bus.cnt1, bus.out0_data, bus.out1_data}); end
    rst = 0;
    drive(0, 0, 8'h00, 0, 1, 1);
  endtask

  task automatic test_round_robin();
    logic [7:0] words[4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, words[i], 1, 1, 1);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rr_in_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      if (i % 2 == 0) begin
        total++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== words[i]) begin bad++; $display("FAIL rr_out0[%0d] got=%b/%h exp=1/%h", i, bus.out0_valid, bus.out0_data, words[i]); end
      end else begin
        total++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== words[i]) begin bad++; $display("FAIL rr_out1[%0d] got=%b/%h exp=1/%h", i, bus.out1_valid, bus.out1_data, words[i]); end
      end
    end
    drive(0, 0, 8'h00, 0, 1, 1);
    tick();
    total++; if (bus.cnt0 !== 16'd2 || bus.cnt1 !== 16'd2) begin bad++; $display("FAIL rr_counts got=%0d/%0d exp=2/2", bus.cnt0, bus.cnt1); end
  endtask

  task automatic test_stall_order();
    int c0;
    c0 = mc[0];
    drive(0, 0, 8'hA1, 1, 0, 1); tick();
    drive(0, 0, 8'hA2, 1, 0, 1); tick();
    total++; if (bus.out0_data !== 8'hA1 || bus.out1_data !== 8'hA2) begin bad++; $display("FAIL stall_bufs got=%h/%h exp=a1/a2", bus.out0_data, bus.out1_data); end
    drive(0, 0, 8'hA3, 1, 0, 1);
    total++; if (bus.in_ready !== 1'b0 || bus.rr_ptr !== 1'b0) begin bad++; $display("FAIL stall_ready got=%b ptr=%b exp=0/0", bus.in_ready, bus.rr_ptr); end
    tick();
    total++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hA1 || bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_hold got=%b/%h/%b exp=1/a1/0", bus.out0_valid, bus.out0_data, bus.in_ready); end
    drive(0, 0, 8'hA3, 1, 1, 1);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL stall_release got=%b exp=1", bus.in_ready); end
    tick();
    total++; if (bus.out0_valid !== 1'b1 || bus.out0_data !== 8'hA3 || bus.cnt0 !== 16'(c0 + 1)) begin bad++; $display("FAIL stall_refill got=%b/%h/%0d exp=1/a3/%0d", bus.out0_valid, bus.out0_data, bus.cnt0, c0 + 1); end
    drive(0, 0, 8'h00, 0, 1, 1); tick();
  endtask

  task automatic test_explicit_select();
    rst = 1; drive(0, 0, 8'h00, 0, 1, 1); tick(); rst = 0;
    drive(0, 0, 8'h0F, 1, 1, 1); tick();
    drive(0, 0, 8'h00, 0, 1, 1); tick();
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, 8'hC0 + 8'(i), 1, 1, 1);
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL sel_ready[%0d] got=%b exp=1", i, bus.in_ready); end
      tick();
      total++; if (bus.out1_valid !== 1'b1 || bus.out1_data !== 8'hC0 + 8'(i) || bus.out0_valid !== 1'b0) begin bad++; $display("FAIL sel_word[%0d] got=%b/%h v0=%b exp=1/%h v0=0", i, bus.out1_valid, bus.out1_data, bus.out0_valid, 8'hC0 + 8'(i)); end
    end
    drive(1, 1, 8'h00, 0, 1, 1); tick();
    total++; if (bus.cnt1 !== 16'd6 || bus.rr_ptr !== 1'b1) begin bad++; $display("FAIL sel_final got=cnt1 %0d ptr %b exp=6/1", bus.cnt1, bus.rr_ptr); end
  endtask

  task automatic test_select_switch();
    drive(1, 1, 8'hB1, 1, 1, 0); tick();
    drive(1, 1, 8'hB2, 1, 1, 0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL switch_full got=%b exp=0", bus.in_ready); end
    drive(1, 0, 8'hB2, 1, 1, 0);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL switch_flip got=%b exp=1", bus.in_ready); end
    drive(1, 0, 8'hB2, 1, 0, 0);
    tick();
    total++; if (bus.out0_data !== 8'hB2 || bus.out1_data !== 8'hB1 || !bus.out0_valid || !bus.out1_valid) begin bad++; $display("FAIL switch_bufs got=%h/%h exp=b2/b1", bus.out0_data, bus.out1_data); end
    drive(1, 0, 8'h00, 0, 1, 1); tick();
  endtask

  task automatic test_counter_wrap();
    rst = 1; tick(); rst = 0;
    bus2.mode = 1; bus2.in_sel = 0; bus2.out0_ready = 1; bus2.out1_ready = 1;
    for (int i = 0; i < 17; i++) begin
      bus2.in_data = 8'(i); bus2.in_valid = 1; tick();
      if (i == 15) begin
        total++; if (bus2.cnt0 !== 4'd15) begin bad++; $display("FAIL wrap_pre got=%0d exp=15", bus2.cnt0); end
      end
    end
    bus2.in_valid = 0; tick();
    total++; if (bus2.cnt0 !== 4'd1 || bus2.cnt1 !== 4'd0) begin bad++; $display("FAIL wrap_cnt0 got=%0d/%0d exp=1/0", bus2.cnt0, bus2.cnt1); end
  endtask

  task automatic test_reset_midway();
    drive(0, 0, 8'hD0, 1, 0, 0); tick();
    drive(0, 0, 8'hD1, 1, 0, 0); tick();
    drive(0, 0, 8'hD2, 1, 0, 0);
    total++; if (!bus.out0_valid || !bus.out1_valid) begin bad++; $display("FAIL mid_held got=%b%b exp=11", bus.out0_valid, bus.out1_valid); end
    rst = 1; drive(0, 0, 8'hD2, 1, 0, 0);
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready got=%b exp=0", bus.in_ready); end
    tick(); rst = 0;
    drive(0, 0, 8'h00, 0, 1, 1);
    total++; if ({bus.out0_valid, bus.out1_valid, bus.rr_ptr} !== 3'b000 || bus.cnt0 !== 16'd0 || bus.cnt1 !== 16'd0) begin bad++; $display("FAIL mid_cleared got=%b/%0d/%0d exp=000/0/0", {bus.out0_valid, bus.out1_valid, bus.rr_ptr}, bus.cnt0, bus.cnt1); end
    tick(); tick();
    total++; if (bus.cnt0 !== 16'd0 || bus.cnt1 !== 16'd0 || bus.out0_valid || bus.out1_valid) begin bad++; $display("FAIL mid_no_delivery got=%0d/%0d exp=0/0", bus.cnt0, bus.cnt1); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 99) < 2);
      drive(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), 8'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      total++; if (bus.in_ready !== m_ready()) begin bad++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", i, bus.in_ready, m_ready()); end
      total++; if (bus.out0_valid !== mv[0] || bus.out1_valid !== mv[1] || bus.rr_ptr !== mp) begin bad++; $display("FAIL rnd_state[%0d] got=%b%b%b exp=%b%b%b", i, bus.out0_valid, bus.out1_valid, bus.rr_ptr, mv[0], mv[1], mp); end
      total++; if (bus.cnt0 !== 16'(mc[0]) || bus.cnt1 !== 16'(mc[1])) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d/%0d exp=%0d/%0d", i, bus.cnt0, bus.cnt1, mc[0], mc[1]); end
      if (!rst && bus.out0_valid && bus.out0_ready && q0.size() > 0) begin
        total++; if (bus.out0_data !== q0[0]) begin bad++; $display("FAIL rnd_order0[%0d] got=%h exp=%h", i, bus.out0_data, q0[0]); end
      end
      if (!rst && bus.out1_valid && bus.out1_ready && q1.size() > 0) begin
        total++; if (bus.out1_data !== q1[0]) begin bad++; $display("FAIL rnd_order1[%0d] got=%h exp=%h", i, bus.out1_data, q1[0]); end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    bus2.mode = 0; bus2.in_sel = 0; bus2.in_data = 8'h00; bus2.in_valid = 0;
    bus2.out0_ready = 1; bus2.out1_ready = 1;
    drive(0, 0, 8'h00, 0, 1, 1);
    test_reset();
    test_round_robin();
    test_stall_order();
    test_explicit_select();
    test_select_switch();
    test_counter_wrap();
    test_reset_midway();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
